// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline status inputs and stall/flush/forward controls of the hazard controller.
//   slave modport  : hazard_ctrl side (reads pipeline status, drives controls).
//   master modport : pipeline side (drives pipeline status, reads controls).
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int PERF_W = 32
);
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic              id_use_rs1, id_use_rs2;
  logic              ex_reg_write, ex_mem_read, ex_branch_taken, ex_muldiv;
  logic              mem_reg_write, wb_reg_write, mem_req, mem_ready;
  logic              pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic              if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [1:0]        fwd_a, fwd_b, state;
  logic              mem_timeout;
  logic [PERF_W-1:0] stall_cycles, flush_events;
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd, ex_reg_write,
           ex_mem_read, ex_branch_taken, ex_muldiv, mem_rd, mem_reg_write, wb_rd,
           wb_reg_write, mem_req, mem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, ex_mem_flush,
           mem_wb_flush, fwd_a, fwd_b, state, mem_timeout, stall_cycles, flush_events
  );
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd, ex_reg_write,
           ex_mem_read, ex_branch_taken, ex_muldiv, mem_rd, mem_reg_write, wb_rd,
           wb_reg_write, mem_req, mem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, ex_mem_flush,
           mem_wb_flush, fwd_a, fwd_b, state, mem_timeout, stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding controller for a 5-stage pipeline.
//   clk : rising-edge clock.  rst : asynchronous active-low reset.
//   bus : hazard_ctrl_if.slave carrying ID/EX/MEM/WB status in, stage enables,
//         bubble flushes, forwarding selects, state, mem_timeout and perf counters out.
//   Optional: define HAZARD_PERF_CNT_EN to build the stall_cycles/flush_events counters.
module hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int MULDIV_LAT  = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int PERF_W      = 32
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);
  localparam int CW = $clog2(MULDIV_LAT + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] MD_INIT = CW'(MULDIV_LAT > 1 ? MULDIV_LAT - 2 : 0);
  localparam logic [WW-1:0] W_MAX = WW'(MEM_TIMEOUT);
  localparam logic [REG_AW-1:0] X0 = '0;
  typedef enum logic [1:0] {RUN = 2'd0, MULDIV = 2'd1, MEM_WAIT = 2'd2} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic            mem_timeout_q, mem_timeout_d;
  logic            memstall, run_mode, load_use, md_start, br;
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs, input logic mw,
                                         input logic [REG_AW-1:0] md, input logic ww,
                                         input logic [REG_AW-1:0] wd);
    return (mw && md != X0 && md == rs) ? 2'b10 : (ww && wd != X0 && wd == rs) ? 2'b01 : 2'b00;
  endfunction
  assign memstall = bus.mem_req && !bus.mem_ready;
  // A MEM_WAIT cycle whose access has completed (or been dropped) behaves exactly like RUN.
  assign run_mode = state_q == RUN || (state_q == MEM_WAIT && !memstall);
  assign load_use = bus.ex_mem_read && bus.ex_rd != X0 &&
                    ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
                     (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
  assign md_start = run_mode && !memstall && bus.ex_muldiv && (MULDIV_LAT > 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      wcnt_q        <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wcnt_q        <= wcnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wcnt_d        = wcnt_q;
    mem_timeout_d = mem_timeout_q;
    if (state_q == MULDIV) begin
      // The op keeps counting through a memstall; the stall only postpones release.
      cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
      state_d = (cnt_q == '0 && !memstall) ? RUN : MULDIV;
    end else if (memstall) begin
      state_d       = MEM_WAIT;
      wcnt_d        = state_q != MEM_WAIT ? '0 : wcnt_q == W_MAX ? W_MAX : wcnt_q + 1'b1;
      mem_timeout_d = mem_timeout_q || (state_q == MEM_WAIT && wcnt_d == W_MAX);
    end else if (md_start) begin
      state_d = MULDIV;
      cnt_d   = MD_INIT;
    end else begin
      state_d = RUN;
    end
  end
  always_comb begin
    {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en} = 4'h0;
    {bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.mem_wb_flush} = 4'h0;
    if (memstall) bus.mem_wb_flush = 1'b1;
    else if (state_q == MULDIV) begin
      if (cnt_q == '0) {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en} = 4'hf;
      else bus.ex_mem_flush = 1'b1;
    end else if (md_start) bus.ex_mem_flush = 1'b1;
    else begin
      {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en} = 4'hf;
      if (load_use) begin
        bus.pc_en       = 1'b0;
        bus.if_id_en    = 1'b0;
        bus.id_ex_flush = 1'b1;
      end
    end
    // A taken branch only redirects when EX actually advances; it beats load-use.
    br = bus.ex_branch_taken && bus.id_ex_en && bus.ex_mem_en;
    if (br) begin
      bus.pc_en       = 1'b1;
      bus.if_id_en    = 1'b1;
      bus.if_id_flush = 1'b1;
      bus.id_ex_flush = 1'b1;
    end
    bus.fwd_a = fwd_sel(bus.ex_rs1, bus.mem_reg_write, bus.mem_rd, bus.wb_reg_write, bus.wb_rd);
    bus.fwd_b = fwd_sel(bus.ex_rs2, bus.mem_reg_write, bus.mem_rd, bus.wb_reg_write, bus.wb_rd);
    if (!rst) begin
      {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en} = 4'h0;
      {bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.mem_wb_flush} = 4'hf;
      bus.fwd_a = 2'b00;
      bus.fwd_b = 2'b00;
      br        = 1'b0;
    end
  end
  assign bus.state       = state_q;
  assign bus.mem_timeout = mem_timeout_q;
`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_q, stall_d, flush_q, flush_d;
  assign stall_d = stall_q + PERF_W'(!bus.pc_en);
  assign flush_d = flush_q + PERF_W'(br);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  assign bus.stall_cycles = stall_q;
  assign bus.flush_events = flush_q;
`else
  assign bus.stall_cycles = {PERF_W{1'b0}};
  assign bus.flush_events = {PERF_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl (MULDIV_LAT=4, MEM_TIMEOUT=8).
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  always #5 clk = ~clk;
  hazard_ctrl_if #(.REG_AW(5), .PERF_W(32)) hif ();
  hazard_ctrl #(.REG_AW(5), .MULDIV_LAT(4), .MEM_TIMEOUT(8), .PERF_W(32)) dut (
    .clk(clk), .rst(rst), .bus(hif.slave)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    {hif.id_rs1, hif.id_rs2, hif.ex_rs1, hif.ex_rs2, hif.ex_rd, hif.mem_rd, hif.wb_rd} = '0;
    {hif.id_use_rs1, hif.id_use_rs2, hif.ex_reg_write, hif.ex_mem_read} = '0;
    {hif.ex_branch_taken, hif.ex_muldiv, hif.mem_reg_write, hif.wb_reg_write} = '0;
    {hif.mem_req, hif.mem_ready} = '0;
  endtask
  initial begin
    clr();
    hif.mem_reg_write = 1'b1; hif.mem_rd = 5'd3; hif.ex_rs1 = 5'd3;
    #2;
    chk("rst_pc_en", hif.pc_en, 1'b0);
    chk("rst_ex_mem_en", hif.ex_mem_en, 1'b0);
    chk("rst_flushes", {hif.if_id_flush, hif.id_ex_flush, hif.ex_mem_flush, hif.mem_wb_flush}, 4'hf);
    chk("rst_fwd_a", hif.fwd_a, 2'b00);
    chk("rst_state", hif.state, 2'd0);
    chk("rst_timeout", hif.mem_timeout, 1'b0);
    tick();
    rst = 1'b1;
    // forwarding priority
    clr();
    hif.mem_reg_write = 1'b1; hif.wb_reg_write = 1'b1;
    hif.mem_rd = 5'd3; hif.wb_rd = 5'd3; hif.ex_rs1 = 5'd3; hif.ex_rs2 = 5'd3;
    #1;
    chk("fwd_a_mem", hif.fwd_a, 2'b10);
    chk("fwd_b_mem", hif.fwd_b, 2'b10);
    chk("idle_ens", {hif.pc_en, hif.if_id_en, hif.id_ex_en, hif.ex_mem_en}, 4'hf);
    chk("idle_flushes", {hif.if_id_flush, hif.id_ex_flush, hif.ex_mem_flush, hif.mem_wb_flush}, 4'h0);
    hif.mem_reg_write = 1'b0;
    #1;
    chk("fwd_a_wb", hif.fwd_a, 2'b01);
    hif.mem_reg_write = 1'b1; hif.mem_rd = 5'd0; hif.wb_rd = 5'd0; hif.ex_rs1 = 5'd0;
    #1;
    chk("fwd_a_x0", hif.fwd_a, 2'b00);
    tick();
    // load-use
    clr();
    hif.ex_mem_read = 1'b1; hif.ex_reg_write = 1'b1; hif.ex_rd = 5'd5;
    hif.id_rs1 = 5'd5; hif.id_use_rs1 = 1'b1;
    #1;
    chk("lu_pc_en", hif.pc_en, 1'b0);
    chk("lu_if_id_en", hif.if_id_en, 1'b0);
    chk("lu_id_ex_flush", hif.id_ex_flush, 1'b1);
    chk("lu_ex_mem_en", hif.ex_mem_en, 1'b1);
    chk("lu_state", hif.state, 2'd0);
    tick();
    clr();
    hif.mem_rd = 5'd5; hif.mem_reg_write = 1'b1;
    #1;
    chk("lu_over_pc_en", hif.pc_en, 1'b1);
    chk("lu_over_id_ex_flush", hif.id_ex_flush, 1'b0);
    tick();
    clr();
    hif.wb_rd = 5'd5; hif.wb_reg_write = 1'b1; hif.ex_rs1 = 5'd5;
    #1;
    chk("lu_fwd_a", hif.fwd_a, 2'b01);
    hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd0; hif.id_rs1 = 5'd0; hif.id_use_rs1 = 1'b1;
    #1;
    chk("lu_x0_pc_en", hif.pc_en, 1'b1);
    tick();
    // branch with load-use in the same cycle
    clr();
    hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd7; hif.id_rs2 = 5'd7; hif.id_use_rs2 = 1'b1;
    hif.ex_branch_taken = 1'b1;
    #1;
    chk("br_pc_en", hif.pc_en, 1'b1);
    chk("br_if_id_flush", hif.if_id_flush, 1'b1);
    chk("br_id_ex_flush", hif.id_ex_flush, 1'b1);
    tick();
    clr();
    #1;
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_flush", hif.flush_events, 32'd1);
    chk("perf_stall", hif.stall_cycles, 32'd1);
`else
    chk("perf_flush_off", hif.flush_events, 32'd0);
    chk("perf_stall_off", hif.stall_cycles, 32'd0);
`endif
    // mul/div, 4-cycle occupancy
    hif.ex_muldiv = 1'b1;
    #1;
    chk("md0_state", hif.state, 2'd0);
    chk("md0_ens", {hif.pc_en, hif.if_id_en, hif.id_ex_en, hif.ex_mem_en}, 4'h0);
    chk("md0_ex_mem_flush", hif.ex_mem_flush, 1'b1);
    tick();
    hif.ex_muldiv = 1'b0;
    #1;
    chk("md1_state", hif.state, 2'd1);
    chk("md1_ens", {hif.pc_en, hif.ex_mem_en}, 2'b00);
    tick();
    chk("md2_ens", {hif.pc_en, hif.ex_mem_en}, 2'b00);
    chk("md2_ex_mem_flush", hif.ex_mem_flush, 1'b1);
    tick();
    chk("md3_ens", {hif.pc_en, hif.if_id_en, hif.id_ex_en, hif.ex_mem_en}, 4'hf);
    chk("md3_state", hif.state, 2'd1);
    tick();
    chk("md_done_state", hif.state, 2'd0);
    // mul/div with a 3-cycle memstall in cycles 3..5
    hif.ex_muldiv = 1'b1;
    #1;
    tick();
    hif.ex_muldiv = 1'b0;
    #1;
    chk("mds2_ex_mem_en", hif.ex_mem_en, 1'b0);
    tick();
    hif.mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mds_stall_ex_mem_en", hif.ex_mem_en, 1'b0);
      chk("mds_stall_state", hif.state, 2'd1);
      chk("mds_stall_wb_flush", hif.mem_wb_flush, 1'b1);
      tick();
    end
    hif.mem_req = 1'b0;
    #1;
    chk("mds6_ex_mem_en", hif.ex_mem_en, 1'b1);
    tick();
    chk("mds_done_state", hif.state, 2'd0);
    // memory timeout, branch held off while frozen
    hif.mem_req = 1'b1; hif.ex_branch_taken = 1'b1;
    #1;
    chk("mw_pc_en", hif.pc_en, 1'b0);
    chk("mw_br_held", hif.if_id_flush, 1'b0);
    chk("mw_wb_flush", hif.mem_wb_flush, 1'b1);
    tick();
    hif.ex_branch_taken = 1'b0;
    chk("mw_state", hif.state, 2'd2);
    repeat (3) tick();
    chk("mw_early_timeout", hif.mem_timeout, 1'b0);
    repeat (8) tick();
    chk("mw_timeout", hif.mem_timeout, 1'b1);
    chk("mw_still_wait", hif.state, 2'd2);
    hif.mem_ready = 1'b1;
    #1;
    chk("mw_release_ens", {hif.pc_en, hif.if_id_en, hif.id_ex_en, hif.ex_mem_en}, 4'hf);
    tick();
    clr();
    #1;
    chk("mw_run", hif.state, 2'd0);
    chk("mw_sticky", hif.mem_timeout, 1'b1);
    rst = 1'b0;
    #1;
    chk("mw_rst_clear", hif.mem_timeout, 1'b0);
    tick();
    rst = 1'b1;
    // asynchronous abort out of MULDIV
    hif.ex_muldiv = 1'b1;
    tick();
    chk("abort_in_md", hif.state, 2'd1);
    rst = 1'b0;
    #1;
    chk("abort_state", hif.state, 2'd0);
    chk("abort_pc_en", hif.pc_en, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
